// File: rtl/encoder_with_priority_pkg.sv
// Shared constants and width helper for the MSB-first priority encoder.
package encoder_with_priority_pkg;

    localparam int unsigned DEFAULT_N = 8;
    localparam int unsigned Y_RST     = 0;
    localparam logic        VALID_RST = 1'b0;
    localparam logic        MULTI_RST = 1'b0;

    // Encoded index width; a 2-input encoder still needs one bit.
    function automatic int unsigned enc_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/encoder_with_priority_prio_enc_comb.sv
// Combinational MSB-first leading-one detector built as a binary tree.
// Leaves beyond N are tied off, so indices >= N can never be produced.
module prio_enc_comb
    import encoder_with_priority_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N,
    parameter int unsigned W = enc_width(N)
) (
    input  logic [N-1:0] i_a,
    output logic [W-1:0] o_idx,
    output logic         o_hit,
    output logic         o_multi
);

    localparam int unsigned P = 1 << W;

    for (genvar l = 0; l <= W; l++) begin : g_lvl
        localparam int unsigned NODES = P >> l;
        logic [NODES-1:0]   hit;
        logic [NODES-1:0]   multi;
        logic [NODES*W-1:0] idx;

        if (l == 0) begin : g_leaf
            for (genvar j = 0; j < NODES; j++) begin : g_node
                if (j < N) begin : g_real
                    assign hit[j] = i_a[j];
                end else begin : g_pad
                    assign hit[j] = 1'b0;
                end
            end
            assign multi = '0;
            assign idx   = '0;
        end else begin : g_merge
            for (genvar j = 0; j < NODES; j++) begin : g_node
                logic w_lo_hit;
                logic w_hi_hit;
                assign w_lo_hit = g_lvl[l-1].hit[2*j];
                assign w_hi_hit = g_lvl[l-1].hit[2*j+1];
                assign hit[j]   = w_lo_hit | w_hi_hit;
                assign multi[j] = g_lvl[l-1].multi[2*j] | g_lvl[l-1].multi[2*j+1]
                                | (w_lo_hit & w_hi_hit);
                // Upper child wins; it contributes bit (l-1) of the index.
                assign idx[j*W +: W] = w_hi_hit
                    ? (g_lvl[l-1].idx[(2*j+1)*W +: W] | W'(32'd1 << (l-1)))
                    : g_lvl[l-1].idx[(2*j)*W +: W];
            end
        end
    end

    assign o_idx   = g_lvl[W].idx[W-1:0];
    assign o_hit   = g_lvl[W].hit[0];
    assign o_multi = g_lvl[W].multi[0];

endmodule

// File: rtl/encoder_with_priority.sv
// Registered MSB-first priority encoder with enable gating.
// Define ENCODER_WITH_PRIORITY_MULTI_HIT_EN to add the registered multi-hit output.
module encoder_with_priority
    import encoder_with_priority_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N,
    parameter int unsigned W = enc_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic         en,
    output logic [W-1:0] y,
    output logic         valid
`ifdef ENCODER_WITH_PRIORITY_MULTI_HIT_EN
    ,
    output logic         multi
`endif
);

    logic [W-1:0] w_idx;
    logic         w_hit;
    logic [W-1:0] w_y_next;
    logic         w_valid_next;
    logic [W-1:0] r_y;
    logic         r_valid;

`ifdef ENCODER_WITH_PRIORITY_MULTI_HIT_EN
    logic w_multi;
    logic w_multi_next;
    logic r_multi;
`else
    logic w_multi_unused;
`endif

    prio_enc_comb #(
        .N (N),
        .W (W)
    ) u_prio (
        .i_a     (a),
        .o_idx   (w_idx),
        .o_hit   (w_hit),
`ifdef ENCODER_WITH_PRIORITY_MULTI_HIT_EN
        .o_multi (w_multi)
`else
        .o_multi (w_multi_unused)
`endif
    );

    // Disabled encoder selects constants, so unknowns on a never reach the registers.
    always_comb begin
        w_y_next     = W'(Y_RST);
        w_valid_next = VALID_RST;
        if (en) begin
            w_y_next     = w_idx;
            w_valid_next = w_hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= W'(Y_RST);
            r_valid <= VALID_RST;
        end else begin
            r_y     <= w_y_next;
            r_valid <= w_valid_next;
        end
    end

    assign y     = r_y;
    assign valid = r_valid;

`ifdef ENCODER_WITH_PRIORITY_MULTI_HIT_EN
    always_comb begin
        w_multi_next = MULTI_RST;
        if (en) begin
            w_multi_next = w_multi;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_multi <= MULTI_RST;
        end else begin
            r_multi <= w_multi_next;
        end
    end

    assign multi = r_multi;
`endif

endmodule

// File: tb/tb_encoder_with_priority.sv
// Scoreboard bench for encoder_with_priority (N=8 and N=5 instances).
module tb_encoder_with_priority;

    typedef struct {
        logic [2:0] y;
        logic       valid;
        logic       multi;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a8 = '0;
    logic       en8 = 1'b0;
    logic [2:0] y8;
    logic       valid8;
    logic [4:0] a5 = '0;
    logic       en5 = 1'b0;
    logic [2:0] y5;
    logic       valid5;
`ifdef ENCODER_WITH_PRIORITY_MULTI_HIT_EN
    logic       multi8;
    logic       multi5;
`endif

    exp_t sb8[$];
    exp_t sb5[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    encoder_with_priority #(.N(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a8),
        .en    (en8),
        .y     (y8),
        .valid (valid8)
`ifdef ENCODER_WITH_PRIORITY_MULTI_HIT_EN
        ,
        .multi (multi8)
`endif
    );

    encoder_with_priority #(.N(5)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a5),
        .en    (en5),
        .y     (y5),
        .valid (valid5)
`ifdef ENCODER_WITH_PRIORITY_MULTI_HIT_EN
        ,
        .multi (multi5)
`endif
    );

    // Reference: scan upward, last set bit is the highest-priority request.
    function automatic exp_t model(input logic [63:0] av, input int n, input logic ev);
        exp_t e;
        int   cnt;
        e.y = 3'd0; e.valid = 1'b0; e.multi = 1'b0; cnt = 0;
        if (ev !== 1'b1) return e;
        for (int i = 0; i < n; i++) begin
            if (av[i] === 1'b1) begin
                e.y = 3'(i);
                cnt++;
            end
        end
        e.valid = (cnt > 0);
        e.multi = (cnt > 1);
        return e;
    endfunction

    task automatic drive8(input logic [7:0] av, input logic ev);
        a8 = av; en8 = ev;
        sb8.push_back(model({56'd0, av}, 8, ev));
    endtask

    task automatic drive5(input logic [4:0] av, input logic ev);
        a5 = av; en5 = ev;
        sb5.push_back(model({59'd0, av}, 5, ev));
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a8 = 8'hff; en8 = 1'b1; a5 = 5'h1f; en5 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks += 4;
        if (y8 !== 3'd0)     begin n_fail++; $display("FAIL reset_y8: got %0d, expected 0", y8); end
        if (valid8 !== 1'b0) begin n_fail++; $display("FAIL reset_valid8: got %b, expected 0", valid8); end
        if (y5 !== 3'd0)     begin n_fail++; $display("FAIL reset_y5: got %0d, expected 0", y5); end
        if (valid5 !== 1'b0) begin n_fail++; $display("FAIL reset_valid5: got %b, expected 0", valid5); end
`ifdef ENCODER_WITH_PRIORITY_MULTI_HIT_EN
        n_checks++;
        if (multi8 !== 1'b0) begin n_fail++; $display("FAIL reset_multi8: got %b, expected 0", multi8); end
`endif
        a8 = '0; en8 = 1'b0; a5 = '0; en5 = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_walking_one();
        exp_t e;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = sb8.pop_front();
                n_checks += 2;
                if (y8 !== e.y)         begin n_fail++; $display("FAIL walk_y[%0d]: got %0d, expected %0d", i-1, y8, e.y); end
                if (valid8 !== e.valid) begin n_fail++; $display("FAIL walk_valid[%0d]: got %b, expected %b", i-1, valid8, e.valid); end
`ifdef ENCODER_WITH_PRIORITY_MULTI_HIT_EN
                n_checks++;
                if (multi8 !== e.multi) begin n_fail++; $display("FAIL walk_multi[%0d]: got %b, expected %b", i-1, multi8, e.multi); end
`endif
            end
            if (i < 8) drive8(8'(32'd1 << i), 1'b1);
        end
    endtask

    task automatic test_priority();
        logic [7:0] vec [4] = '{8'b1010_0110, 8'b0000_0110, 8'b1000_0001, 8'b0100_0000};
        exp_t e;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = sb8.pop_front();
                n_checks += 2;
                if (y8 !== e.y)         begin n_fail++; $display("FAIL prio_y[%0d]: got %0d, expected %0d", i-1, y8, e.y); end
                if (valid8 !== e.valid) begin n_fail++; $display("FAIL prio_valid[%0d]: got %b, expected %b", i-1, valid8, e.valid); end
`ifdef ENCODER_WITH_PRIORITY_MULTI_HIT_EN
                n_checks++;
                if (multi8 !== e.multi) begin n_fail++; $display("FAIL prio_multi[%0d]: got %b, expected %b", i-1, multi8, e.multi); end
`endif
            end
            if (i < 4) drive8(vec[i], 1'b1);
        end
    endtask

    task automatic test_disable_and_zero();
        logic [7:0] vec [4] = '{8'bxxxx_xxxx, 8'hff, 8'h00, 8'hff};
        logic       ens [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_t e;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = sb8.pop_front();
                n_checks += 2;
                if (y8 !== e.y)         begin n_fail++; $display("FAIL dis_y[%0d]: got %b, expected %b", i-1, y8, e.y); end
                if (valid8 !== e.valid) begin n_fail++; $display("FAIL dis_valid[%0d]: got %b, expected %b", i-1, valid8, e.valid); end
`ifdef ENCODER_WITH_PRIORITY_MULTI_HIT_EN
                n_checks++;
                if (multi8 !== e.multi) begin n_fail++; $display("FAIL dis_multi[%0d]: got %b, expected %b", i-1, multi8, e.multi); end
`endif
            end
            if (i < 4) drive8(vec[i], ens[i]);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        @(negedge clk);
        drive8(8'b0010_0000, 1'b1);
        @(posedge clk);
        #2;
        e = sb8.pop_front();
        n_checks++;
        if (y8 !== e.y) begin n_fail++; $display("FAIL arst_pre_y: got %0d, expected %0d", y8, e.y); end
        rst_n = 1'b0;
        #1;
        n_checks += 2;
        if (y8 !== 3'd0)     begin n_fail++; $display("FAIL arst_now_y: got %0d, expected 0", y8); end
        if (valid8 !== 1'b0) begin n_fail++; $display("FAIL arst_now_valid: got %b, expected 0", valid8); end
        @(negedge clk);
        a8 = 8'b0000_1000; en8 = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (y8 !== 3'd0) begin n_fail++; $display("FAIL arst_hold_y: got %0d, expected 0", y8); end
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (y8 !== 3'd0) begin n_fail++; $display("FAIL arst_release_y: got %0d, expected 0", y8); end
        drive8(8'b0000_1000, 1'b1);
        @(negedge clk);
        e = sb8.pop_front();
        n_checks += 2;
        if (y8 !== e.y)         begin n_fail++; $display("FAIL arst_first_y: got %0d, expected %0d", y8, e.y); end
        if (valid8 !== e.valid) begin n_fail++; $display("FAIL arst_first_valid: got %b, expected %b", valid8, e.valid); end
        en8 = 1'b0; a8 = '0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i <= 40; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = sb8.pop_front();
                n_checks += 2;
                if (y8 !== e.y)         begin n_fail++; $display("FAIL b2b_y[%0d]: got %0d, expected %0d", i-1, y8, e.y); end
                if (valid8 !== e.valid) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b, expected %b", i-1, valid8, e.valid); end
`ifdef ENCODER_WITH_PRIORITY_MULTI_HIT_EN
                n_checks++;
                if (multi8 !== e.multi) begin n_fail++; $display("FAIL b2b_multi[%0d]: got %b, expected %b", i-1, multi8, e.multi); end
`endif
            end
            if (i < 40) drive8(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
        end
    endtask

    task automatic test_n5();
        exp_t e;
        for (int i = 0; i <= 34; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = sb5.pop_front();
                n_checks += 3;
                if (y5 !== e.y)         begin n_fail++; $display("FAIL n5_y[%0d]: got %0d, expected %0d", i-1, y5, e.y); end
                if (valid5 !== e.valid) begin n_fail++; $display("FAIL n5_valid[%0d]: got %b, expected %b", i-1, valid5, e.valid); end
                if (!(y5 <= 3'd4))      begin n_fail++; $display("FAIL n5_range[%0d]: got %0d, expected <= 4", i-1, y5); end
`ifdef ENCODER_WITH_PRIORITY_MULTI_HIT_EN
                n_checks++;
                if (multi5 !== e.multi) begin n_fail++; $display("FAIL n5_multi[%0d]: got %b, expected %b", i-1, multi5, e.multi); end
`endif
            end
            if (i == 0)       drive5(5'b10000, 1'b1);
            else if (i == 1)  drive5(5'b00011, 1'b1);
            else if (i < 34)  drive5(5'(i - 2), 1'b1);
        end
        en5 = 1'b0; a5 = '0;
    endtask

    initial begin
        test_reset();
        test_walking_one();
        test_priority();
        test_disable_and_zero();
        test_async_reset();
        test_back_to_back();
        test_n5();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
